// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 slave backed by a word-addressed on-chip SRAM
module axi_sram_slave #(
   parameter int ADDR_WIDTH = 12,
   parameter int RD_WAIT    = 0,
   parameter int MAX_LEN    = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready
);

   localparam int                    DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [3:0]            MAX_LEN_C = 4'(MAX_LEN);
   localparam logic [3:0]            RD_WAIT_C = 4'(RD_WAIT);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_DATA,
      S_WR_RESP,
      S_RD_WAIT,
      S_RD_DATA
   } state_t;

   state_t                state_q;
   logic [31:0]           mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [3:0]            id_q;
   logic [3:0]            len_q;
   logic [3:0]            cnt_q;
   logic [3:0]            wait_q;
   logic                  err_q;
   logic                  awready_q;
   logic                  wready_q;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;
   logic                  rvalid_q;
   logic                  rlast_q;

   logic [3:0]            awlen_d;
   logic [3:0]            arlen_d;
   logic                  aw_hs;
   logic                  ar_hs;
   logic                  w_hs;
   logic                  r_hs;
   logic                  len_hit;
   logic                  wlast_bad;
   logic                  unused_ok;

   // Oversized bursts are clamped; only the low 4 bits can survive the clamp.
   assign awlen_d   = (awlen > {4'b0000, MAX_LEN_C}) ? MAX_LEN_C : awlen[3:0];
   assign arlen_d   = (arlen > {4'b0000, MAX_LEN_C}) ? MAX_LEN_C : arlen[3:0];

   // Writes win contention: AR is only offered while no AW is pending.
   assign arready   = awready_q & ~awvalid;
   assign aw_hs     = awvalid & awready_q;
   assign ar_hs     = arvalid & arready;
   assign w_hs      = wvalid & wready_q;
   assign r_hs      = rvalid_q & rready;
   assign len_hit   = (cnt_q == len_q);
   assign wlast_bad = (wlast != len_hit);

   assign awready   = awready_q;
   assign wready    = wready_q;
   assign bvalid    = bvalid_q;
   assign bresp     = bresp_q;
   assign bid       = id_q;
   assign rid       = id_q;
   assign rvalid    = rvalid_q;
   assign rlast     = rlast_q;
   assign rresp     = 2'b00;
   assign rdata     = rvalid_q ? mem_q[addr_q] : 32'h0000_0000;

   // Size, burst type, WID and sub-word/aliased address bits have no effect.
   assign unused_ok = ^{awsize, awburst, wid, arsize, arburst,
                        awaddr[31:ADDR_WIDTH+2], awaddr[1:0],
                        araddr[31:ADDR_WIDTH+2], araddr[1:0]};

   // Byte-enabled SRAM write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (w_hs) begin
         if (wstrb[0]) mem_q[addr_q][7:0]   <= wdata[7:0];
         if (wstrb[1]) mem_q[addr_q][15:8]  <= wdata[15:8];
         if (wstrb[2]) mem_q[addr_q][23:16] <= wdata[23:16];
         if (wstrb[3]) mem_q[addr_q][31:24] <= wdata[31:24];
      end
   end

   // Transaction FSM with registered handshake outputs; one burst at a time.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         id_q      <= 4'd0;
         len_q     <= 4'd0;
         cnt_q     <= 4'd0;
         wait_q    <= 4'd0;
         err_q     <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               awready_q <= 1'b1;
               if (aw_hs) begin
                  id_q      <= awid;
                  addr_q    <= awaddr[ADDR_WIDTH+1:2];
                  len_q     <= awlen_d;
                  cnt_q     <= 4'd0;
                  err_q     <= 1'b0;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  state_q   <= S_WR_DATA;
               end else if (ar_hs) begin
                  id_q      <= arid;
                  addr_q    <= araddr[ADDR_WIDTH+1:2];
                  len_q     <= arlen_d;
                  cnt_q     <= 4'd0;
                  wait_q    <= RD_WAIT_C;
                  awready_q <= 1'b0;
                  if (RD_WAIT_C != 4'd0) begin
                     state_q <= S_RD_WAIT;
                  end else begin
                     state_q  <= S_RD_DATA;
                     rvalid_q <= 1'b1;
                     rlast_q  <= (arlen_d == 4'd0);
                  end
               end
            end
            S_WR_DATA: begin
               if (w_hs) begin
                  addr_q <= addr_q + ADDR_ONE;
                  cnt_q  <= cnt_q + 4'd1;
                  if (wlast_bad) err_q <= 1'b1;
                  // Whichever of wlast or the beat count comes first closes the burst.
                  if (len_hit || wlast) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bresp_q  <= (err_q || wlast_bad) ? 2'b10 : 2'b00;
                     state_q  <= S_WR_RESP;
                  end
               end
            end
            S_WR_RESP: begin
               if (bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  state_q   <= S_IDLE;
               end
            end
            S_RD_WAIT: begin
               // Counter runs out RD_WAIT cycles, plus the cycle spent leaving.
               if (wait_q == 4'd0) begin
                  state_q  <= S_RD_DATA;
                  rvalid_q <= 1'b1;
                  rlast_q  <= (len_q == 4'd0);
               end else begin
                  wait_q <= wait_q - 4'd1;
               end
            end
            S_RD_DATA: begin
               if (r_hs) begin
                  addr_q <= addr_q + ADDR_ONE;
                  cnt_q  <= cnt_q + 4'd1;
                  if (rlast_q) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     awready_q <= 1'b1;
                     state_q   <= S_IDLE;
                  end else begin
                     rlast_q <= ((cnt_q + 4'd1) == len_q);
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - directed bench for axi_sram_slave
module tb_axi_sram_slave;

   logic        clk;
   logic        reset;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   int errors = 0;
   int checks = 0;

   axi_sram_slave #(
      .ADDR_WIDTH (8),
      .RD_WAIT    (3),
      .MAX_LEN    (15)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .awid    (awid),
      .awaddr  (awaddr),
      .awlen   (awlen),
      .awsize  (awsize),
      .awburst (awburst),
      .awvalid (awvalid),
      .awready (awready),
      .wid     (wid),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wlast   (wlast),
      .wvalid  (wvalid),
      .wready  (wready),
      .bid     (bid),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready),
      .arid    (arid),
      .araddr  (araddr),
      .arlen   (arlen),
      .arsize  (arsize),
      .arburst (arburst),
      .arvalid (arvalid),
      .arready (arready),
      .rid     (rid),
      .rdata   (rdata),
      .rresp   (rresp),
      .rlast   (rlast),
      .rvalid  (rvalid),
      .rready  (rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] wr_addr;
      logic [31:0] rd_addr;
      logic [31:0] pre;
      logic [31:0] wdat;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tmo(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for handshake", nm);
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_awready"}, 32'(awready), 32'd0);
      chk({nm, "_arready"}, 32'(arready), 32'd0);
      chk({nm, "_wready"},  32'(wready),  32'd0);
      chk({nm, "_bvalid"},  32'(bvalid),  32'd0);
      chk({nm, "_rvalid"},  32'(rvalid),  32'd0);
      chk({nm, "_rlast"},   32'(rlast),   32'd0);
      chk({nm, "_bid"},     32'(bid),     32'd0);
      chk({nm, "_rid"},     32'(rid),     32'd0);
      chk({nm, "_bresp"},   32'(bresp),   32'd0);
      chk({nm, "_rresp"},   32'(rresp),   32'd0);
      chk({nm, "_rdata"},   rdata,        32'd0);
   endtask

   task automatic aw(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
      int n = 0;
      awaddr = a; awlen = len; awid = id; awvalid = 1'b1;
      #1;
      while (!awready && n < 50) begin @(negedge clk); #1; n++; end
      if (!awready) tmo("aw");
      @(negedge clk);
      awvalid = 1'b0;
   endtask

   task automatic ar(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
      int n = 0;
      araddr = a; arlen = len; arid = id; arvalid = 1'b1;
      #1;
      while (!arready && n < 50) begin @(negedge clk); #1; n++; end
      if (!arready) tmo("ar");
      @(negedge clk);
      arvalid = 1'b0;
   endtask

   task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
      int n = 0;
      wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
      #1;
      while (!wready && n < 50) begin @(negedge clk); #1; n++; end
      if (!wready) tmo("w_beat");
      @(negedge clk);
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic b_wait(input logic [1:0] er, input logic [3:0] eid, input string nm);
      int n = 0;
      bready = 1'b1;
      #1;
      while (!bvalid && n < 50) begin @(negedge clk); #1; n++; end
      if (!bvalid) tmo({nm, "_b"});
      else begin
         chk({nm, "_bresp"}, 32'(bresp), 32'(er));
         chk({nm, "_bid"},   32'(bid),   32'(eid));
      end
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic r_beat(input logic [31:0] ed, input logic el, input logic [3:0] eid,
                         input logic stall, input string nm);
      int n = 0;
      rready = ~stall;
      #1;
      while (!rvalid && n < 50) begin @(negedge clk); #1; n++; end
      if (!rvalid) begin
         tmo({nm, "_r"});
      end else begin
         chk({nm, "_rdata"}, rdata,         ed);
         chk({nm, "_rlast"}, 32'(rlast),    32'(el));
         chk({nm, "_rid"},   32'(rid),      32'(eid));
         chk({nm, "_rresp"}, 32'(rresp),    32'd0);
         if (stall) begin
            @(negedge clk); #1;
            chk({nm, "_hold_rdata"}, rdata,      ed);
            chk({nm, "_hold_rlast"}, 32'(rlast), 32'(el));
            rready = 1'b1;
         end
      end
      @(negedge clk);
      rready = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      awid = 0; awaddr = 0; awlen = 0; awsize = 3'b010; awburst = 2'b01; awvalid = 0;
      wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
      arid = 0; araddr = 0; arlen = 0; arsize = 3'b010; arburst = 2'b01; arvalid = 0;
      rready = 0;

      vecs[0] = '{32'h020, 32'h020, 32'h1122_3344, 32'hAABB_CCDD, 4'b0101, 32'h11BB_33DD};
      vecs[1] = '{32'h024, 32'h024, 32'h1122_3344, 32'hAABB_CCDD, 4'b1010, 32'hAA22_CC44};
      vecs[2] = '{32'h028, 32'h028, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0001, 32'hFFFF_FF00};
      vecs[3] = '{32'h02C, 32'h02C, 32'h0000_0000, 32'h1234_5678, 4'b1000, 32'h1200_0000};
      vecs[4] = '{32'h030, 32'h030, 32'hCAFE_F00D, 32'h0000_0000, 4'b0000, 32'hCAFE_F00D};
      vecs[5] = '{32'h434, 32'h034, 32'h0102_0304, 32'hA0B0_C0D0, 4'b1100, 32'hA0B0_0304};

      // reset state
      repeat (3) @(negedge clk);
      check_zero("rst");
      reset = 1'b1;
      @(negedge clk);
      chk("rst_rel_awready", 32'(awready), 32'd1);
      chk("rst_rel_arready", 32'(arready), 32'd1);

      // single beat
      aw(32'h10, 8'd0, 4'd3);
      w_beat(32'hDEAD_BEEF, 4'hF, 1'b1);
      chk("single_bvalid_next", 32'(bvalid), 32'd1);
      b_wait(2'b00, 4'd3, "single");
      ar(32'h10, 8'd0, 4'd5);
      r_beat(32'hDEAD_BEEF, 1'b1, 4'd5, 1'b0, "single");

      // strobe table
      for (int i = 0; i < 6; i++) begin
         aw(vecs[i].wr_addr, 8'd0, 4'(i));
         w_beat(vecs[i].pre, 4'hF, 1'b1);
         b_wait(2'b00, 4'(i), $sformatf("tbl%0d_pre", i));
         aw(vecs[i].wr_addr, 8'd0, 4'(i));
         w_beat(vecs[i].wdat, vecs[i].strb, 1'b1);
         b_wait(2'b00, 4'(i), $sformatf("tbl%0d_wr", i));
         ar(vecs[i].rd_addr, 8'd0, 4'(i + 8));
         r_beat(vecs[i].exp, 1'b1, 4'(i + 8), 1'b0, $sformatf("tbl%0d", i));
      end

      // contention: AW and AR together, write first
      aw(32'h40, 8'd0, 4'd6);
      w_beat(32'h1122_3344, 4'hF, 1'b1);
      b_wait(2'b00, 4'd6, "cont_pre");
      araddr = 32'h40; arlen = 0; arid = 4'd7; arvalid = 1'b1;
      awaddr = 32'h40; awlen = 0; awid = 4'd6; awvalid = 1'b1;
      #1;
      chk("cont_arready", 32'(arready), 32'd0);
      chk("cont_awready", 32'(awready), 32'd1);
      @(negedge clk);
      awvalid = 1'b0;
      w_beat(32'hAABB_CCDD, 4'b0101, 1'b1);
      b_wait(2'b00, 4'd6, "cont_wr");
      ar(32'h40, 8'd0, 4'd7);
      r_beat(32'h11BB_33DD, 1'b1, 4'd7, 1'b0, "cont_rd");

      // line burst with B backpressure, RD_WAIT latency and R stalls
      aw(32'h100, 8'd15, 4'd1);
      for (int i = 0; i < 16; i++) w_beat(32'h1000 + 32'(i), 4'hF, (i == 15));
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bhold%0d_bvalid", k), 32'(bvalid), 32'd1);
         chk($sformatf("bhold%0d_wready", k), 32'(wready), 32'd0);
         @(negedge clk);
      end
      b_wait(2'b00, 4'd1, "line");
      ar(32'h100, 8'd15, 4'd2);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("lat%0d_rvalid", k), 32'(rvalid), 32'd0);
         @(negedge clk);
      end
      chk("lat4_rvalid", 32'(rvalid), 32'd1);
      for (int i = 0; i < 16; i++)
         r_beat(32'h1000 + 32'(i), (i == 15), 4'd2, i[0], $sformatf("line%0d", i));
      chk("line_rvalid_after", 32'(rvalid), 32'd0);

      // oversized arlen clamps to 16 beats
      ar(32'h100, 8'd40, 4'd3);
      for (int i = 0; i < 16; i++)
         r_beat(32'h1000 + 32'(i), (i == 15), 4'd3, 1'b0, $sformatf("clamp%0d", i));
      chk("clamp_rvalid_after", 32'(rvalid), 32'd0);

      // protocol errors
      aw(32'h88, 8'd1, 4'd4);
      w_beat(32'h5555_5555, 4'hF, 1'b0);
      w_beat(32'h6666_6666, 4'hF, 1'b1);
      b_wait(2'b00, 4'd4, "err_pre");
      aw(32'h80, 8'd3, 4'd5);
      w_beat(32'h0000_00A1, 4'hF, 1'b0);
      w_beat(32'h0000_00A2, 4'hF, 1'b1);
      chk("early_wready", 32'(wready), 32'd0);
      b_wait(2'b10, 4'd5, "early");
      ar(32'h80, 8'd3, 4'd5);
      r_beat(32'h0000_00A1, 1'b0, 4'd5, 1'b0, "early0");
      r_beat(32'h0000_00A2, 1'b0, 4'd5, 1'b0, "early1");
      r_beat(32'h5555_5555, 1'b0, 4'd5, 1'b0, "early2");
      r_beat(32'h6666_6666, 1'b1, 4'd5, 1'b0, "early3");
      aw(32'h90, 8'd1, 4'd6);
      w_beat(32'h0000_00B1, 4'hF, 1'b0);
      w_beat(32'h0000_00B2, 4'hF, 1'b0);
      chk("nolast_wready", 32'(wready), 32'd0);
      b_wait(2'b10, 4'd6, "nolast");
      ar(32'h90, 8'd1, 4'd6);
      r_beat(32'h0000_00B1, 1'b0, 4'd6, 1'b0, "nolast0");
      r_beat(32'h0000_00B2, 1'b1, 4'd6, 1'b0, "nolast1");

      // address wrap from the last word to word 0
      aw(32'h3FC, 8'd1, 4'd8);
      w_beat(32'h7777_7777, 4'hF, 1'b0);
      w_beat(32'h8888_8888, 4'hF, 1'b1);
      b_wait(2'b00, 4'd8, "wrap_wr");
      ar(32'h3FC, 8'd1, 4'd9);
      r_beat(32'h7777_7777, 1'b0, 4'd9, 1'b0, "wrap0");
      r_beat(32'h8888_8888, 1'b1, 4'd9, 1'b0, "wrap1");

      // reset during beat 7 of a 16-beat write
      aw(32'h100, 8'd15, 4'd10);
      for (int i = 0; i < 7; i++) w_beat(32'h2000 + 32'(i), 4'hF, 1'b0);
      wdata = 32'h2007; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      reset = 1'b0;
      #1;
      check_zero("midrst");
      wvalid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_rel_awready", 32'(awready), 32'd1);
      chk("midrst_rel_bvalid",  32'(bvalid),  32'd0);
      ar(32'h100, 8'd15, 4'd11);
      for (int i = 0; i < 16; i++)
         r_beat((i < 7) ? (32'h2000 + 32'(i)) : (32'h1000 + 32'(i)), (i == 15), 4'd11, 1'b0,
                $sformatf("midrst%0d", i));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
